// File: rtl/batcharger_pkg.sv
// Shared state encoding, mode-bit positions and output decode for the charge sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package batcharger_pkg;

    // State codes are also the debug encoding on state_o.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_TC    = 3'd2;
    localparam logic [2:0] ST_CC    = 3'd3;
    localparam logic [2:0] ST_CV    = 3'd4;
    localparam logic [2:0] ST_END   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_TC    = ST_TC,
        S_CC    = ST_CC,
        S_CV    = ST_CV,
        S_END   = ST_END
    } state_e;

    // Bit positions of the one-hot forcing mode inside outs_t.mode.
    localparam int MODE_TC = 0;
    localparam int MODE_CC = 1;
    localparam int MODE_CV = 2;

    typedef struct packed {
        logic [2:0] mode;     // {cv, cc, tc}
        logic       imonen;
        logic       vmonen;
        logic       tmonen;
    } outs_t;

    // Output pattern for each state. Anything not a legal state decodes to all-off.
    function automatic outs_t decode_outs(input logic [2:0] st);
        outs_t o;
        o = '0;
        case (st)
            ST_START: begin
                o.imonen = 1'b1;
                o.vmonen = 1'b1;
                o.tmonen = 1'b1;
            end
            ST_TC, ST_CC, ST_CV: begin
                o.imonen = 1'b1;
                o.vmonen = 1'b1;
                o.tmonen = 1'b1;
                if (st == ST_TC) o.mode[MODE_TC] = 1'b1;
                if (st == ST_CC) o.mode[MODE_CC] = 1'b1;
                if (st == ST_CV) o.mode[MODE_CV] = 1'b1;
            end
            ST_END: begin
                // Current forcing is off, so the current monitor is parked.
                o.vmonen = 1'b1;
                o.tmonen = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/batcharger_cv_timer.sv
// CV safety timer: 2**PRESC prescaler feeding a saturating TW-bit tick counter.
// Latency: cnt_o updates on the edge after clr_i/run_i are sampled.
// Backpressure: none; clr_i has priority over run_i, counter holds when neither is set.
//
// Ports:
//   clk    in  1   clock, rising edge
//   rstz   in  1   synchronous active-low reset
//   clr_i  in  1   clear prescaler and counter
//   run_i  in  1   advance prescaler this cycle
//   cnt_o  out TW  prescaled tick count, saturates at all-ones
module batcharger_cv_timer #(
    parameter int TW    = 16,
    parameter int PRESC = 8
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          clr_i,
    input  logic          run_i,
    output logic [TW-1:0] cnt_o
);

    // PRESC=0 still needs a one-bit register; PMAX=0 then wraps every cycle.
    localparam int            PW   = (PRESC > 0) ? PRESC : 1;
    localparam logic [PW-1:0] PMAX = PW'((64'd1 << PRESC) - 64'd1);

    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (run_i) begin
            if (pre_q == PMAX) begin
                pre_d = '0;
                if (cnt_q != {TW{1'b1}}) cnt_d = cnt_q + TW'(1);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/batcharger_ctrl.sv
// Charge sequencer: temperature-qualified IDLE/START/TC/CC/CV/END FSM driving mode selects and monitor enables.
// Latency: outputs are registered from next-state, so they change on the same edge as the state.
// Backpressure: none; ADC codes and thresholds are sampled combinationally every cycle.
//
// Ports:
//   clk, rstz                  clock and synchronous active-low reset
//   en                         charger enable (level)
//   vbat, ibat, vtemp          ADC codes
//   vcutoff, vpreset, vtarget  voltage thresholds; iend termination current
//   tempmin, tempmax           inclusive temperature window; tmax CV timeout in ticks
//   tc, cc, cv                 one-hot forcing mode selects
//   imonen, vmonen, tmonen     monitor enables
//   state_o                    current state code
module batcharger_ctrl
    import batcharger_pkg::*;
#(
    parameter int DW    = 8,
    parameter int TW    = 16,
    parameter int PRESC = 8
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          en,
    input  logic [DW-1:0] vbat,
    input  logic [DW-1:0] ibat,
    input  logic [DW-1:0] vtemp,
    input  logic [DW-1:0] vcutoff,
    input  logic [DW-1:0] vpreset,
    input  logic [DW-1:0] vtarget,
    input  logic [DW-1:0] iend,
    input  logic [DW-1:0] tempmin,
    input  logic [DW-1:0] tempmax,
    input  logic [TW-1:0] tmax,
    output logic          tc,
    output logic          cc,
    output logic          cv,
    output logic          imonen,
    output logic          vmonen,
    output logic          tmonen,
    output logic [2:0]    state_o
);

    logic [2:0]    state_q, state_d;
    outs_t         outs_q, outs_d;
    logic          tok;
    logic          timer_clr, timer_run;
    logic [TW-1:0] timer_cnt;

    assign tok = (vtemp >= tempmin) && (vtemp <= tempmax);

    // Next-state logic. Enable loss beats everything; within a state the
    // temperature fault is checked before any voltage/current condition.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_START;
                ST_START: begin
                    if (!tok)                state_d = ST_START;
                    else if (vbat < vcutoff) state_d = ST_TC;
                    else if (vbat < vpreset) state_d = ST_CC;
                    else                     state_d = ST_END;
                end
                ST_TC: begin
                    if (!tok)                 state_d = ST_START;
                    else if (vbat >= vcutoff) state_d = ST_CC;
                end
                ST_CC: begin
                    if (!tok)                 state_d = ST_START;
                    else if (vbat >= vtarget) state_d = ST_CV;
                end
                ST_CV: begin
                    if (!tok)                                    state_d = ST_START;
                    else if ((ibat <= iend) || (timer_cnt >= tmax)) state_d = ST_END;
                end
                ST_END: begin
                    if (vbat < vpreset) state_d = ST_START;
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign outs_d = decode_outs(state_d);

    // Timer starts from zero on each CV entry and is also dropped whenever the
    // sequencer is sent back to IDLE; it only advances while sitting in CV.
    assign timer_clr = ((state_d == ST_CV) && (state_q != ST_CV)) || (state_d == ST_IDLE);
    assign timer_run = (state_q == ST_CV);

    batcharger_cv_timer #(
        .TW    (TW),
        .PRESC (PRESC)
    ) u_cv_timer (
        .clk   (clk),
        .rstz  (rstz),
        .clr_i (timer_clr),
        .run_i (timer_run),
        .cnt_o (timer_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_q <= ST_IDLE;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
        end
    end

    assign tc      = outs_q.mode[MODE_TC];
    assign cc      = outs_q.mode[MODE_CC];
    assign cv      = outs_q.mode[MODE_CV];
    assign imonen  = outs_q.imonen;
    assign vmonen  = outs_q.vmonen;
    assign tmonen  = outs_q.tmonen;
    assign state_o = state_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Scoreboard bench for the charge sequencer: each stimulus row pushes its expected
// {state, tc, cc, cv, imonen, vmonen, tmonen} and the value is popped after the edge.
// The timer prescaler is shortened to 2 bits so the CV timeout is reachable quickly.
module tb_batcharger_ctrl;

    logic        clk = 1'b0;
    logic        rstz, en;
    logic [7:0]  vbat, ibat, vtemp, vcutoff, vpreset, vtarget, iend, tempmin, tempmax;
    logic [15:0] tmax;
    logic        tc, cc, cv, imonen, vmonen, tmonen;
    logic [2:0]  state_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] sb [$];
    logic [8:0] obs;
    assign obs = {state_o, tc, cc, cv, imonen, vmonen, tmonen};

    typedef struct packed {
        logic        rstz;
        logic        en;
        logic [7:0]  vbat;
        logic [7:0]  ibat;
        logic [7:0]  vtemp;
        logic [15:0] tmax;
        logic [2:0]  st;
    } row_t;

    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, TC = 3'd2, CC = 3'd3, CV = 3'd4, ENDS = 3'd5;

    batcharger_ctrl #(.DW(8), .TW(16), .PRESC(2)) dut (
        .clk(clk), .rstz(rstz), .en(en),
        .vbat(vbat), .ibat(ibat), .vtemp(vtemp),
        .vcutoff(vcutoff), .vpreset(vpreset), .vtarget(vtarget), .iend(iend),
        .tempmin(tempmin), .tempmax(tempmax), .tmax(tmax),
        .tc(tc), .cc(cc), .cv(cv),
        .imonen(imonen), .vmonen(vmonen), .tmonen(tmonen),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference output pattern per state: {state, tc, cc, cv, imonen, vmonen, tmonen}.
    function automatic logic [8:0] expv(input logic [2:0] st);
        case (st)
            IDLE:    return {IDLE,  3'b000, 3'b000};
            START:   return {START, 3'b000, 3'b111};
            TC:      return {TC,    3'b100, 3'b111};
            CC:      return {CC,    3'b010, 3'b111};
            CV:      return {CV,    3'b001, 3'b111};
            ENDS:    return {ENDS,  3'b000, 3'b011};
            default: return {IDLE,  3'b000, 3'b000};
        endcase
    endfunction

    function automatic row_t mk(input logic r, input logic e, input logic [7:0] vb,
                                input logic [7:0] ib, input logic [7:0] vt,
                                input logic [15:0] tm, input logic [2:0] st);
        row_t x;
        x.rstz = r; x.en = e; x.vbat = vb; x.ibat = ib; x.vtemp = vt; x.tmax = tm; x.st = st;
        return x;
    endfunction

    // Apply one row's inputs and record what the DUT must show after the next edge.
    task automatic drive(input row_t r);
        rstz  = r.rstz;
        en    = r.en;
        vbat  = r.vbat;
        ibat  = r.ibat;
        vtemp = r.vtemp;
        tmax  = r.tmax;
        sb.push_back(expv(r.st));
    endtask

    task automatic test_reset();
        row_t rows [$];
        logic [8:0] exp;
        rows = '{mk(0, 0, 30, 100, 100, 1000, IDLE),
                 mk(0, 1, 30, 100, 100, 1000, IDLE)};   // reset beats en
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_full_charge();
        row_t rows [$];
        logic [8:0] exp;
        rows = '{mk(1, 1,  30, 100, 100, 1000, START),
                 mk(1, 1,  30, 100, 100, 1000, TC),
                 mk(1, 1,  45, 100, 100, 1000, TC),
                 mk(1, 1,  59, 100, 100, 1000, TC),
                 mk(1, 1,  60, 100, 100, 1000, CC),     // vbat == vcutoff
                 mk(1, 1, 120, 100, 100, 1000, CC),
                 mk(1, 1, 199, 100, 100, 1000, CC),
                 mk(1, 1, 200, 100, 100, 1000, CV),
                 mk(1, 1, 200, 100, 100, 1000, CV),
                 mk(1, 1, 200,   8, 100, 1000, ENDS),
                 mk(1, 1, 200,   8, 100, 1000, ENDS)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL full_charge[%0d]: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_temp_fault();
        row_t rows [$];
        logic [8:0] exp;
        rows = '{mk(1, 0, 150, 100, 100, 1000, IDLE),
                 mk(1, 1, 150, 100, 100, 1000, START),
                 mk(1, 1, 150, 100, 100, 1000, CC),
                 mk(1, 1, 150, 100, 220, 1000, CC),     // vtemp == tempmax is ok
                 mk(1, 1, 150, 100, 250, 1000, START),
                 mk(1, 1, 150, 100, 250, 1000, START),
                 mk(1, 1, 150, 100,  19, 1000, START),
                 mk(1, 1, 150, 100,  20, 1000, CC),     // vtemp == tempmin is ok
                 mk(1, 1, 150, 100, 100, 1000, CC)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL temp_fault[%0d]: got %b want %b", i, obs, exp);
            end
        end
    endtask

    // Leaves CV part-way through a timeout count; the following timeout test
    // only lands on the right edge if that partial count was discarded.
    task automatic test_en_drop();
        row_t rows [$];
        logic [8:0] exp;
        rows = '{mk(1, 1, 200, 100, 100, 5, CV),
                 mk(1, 1, 200, 100, 100, 5, CV),
                 mk(1, 1, 200, 100, 100, 5, CV),
                 mk(1, 1, 200, 100, 100, 5, CV),
                 mk(1, 1, 200, 100, 100, 5, CV),
                 mk(1, 1, 200, 100, 100, 5, CV),
                 mk(1, 0, 200, 100, 100, 5, IDLE),
                 mk(1, 0, 200, 100, 100, 5, IDLE),
                 mk(1, 1, 150, 100, 100, 5, START),
                 mk(1, 1, 150, 100, 100, 5, CC)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL en_drop[%0d]: got %b want %b", i, obs, exp);
            end
        end
    endtask

    // PRESC=2, tmax=5: the timer reaches 5 on the 20th edge spent in CV, so the
    // exit to END is taken on the 21st edge after the entry edge (20 clk after the
    // first CV edge). Step 0 is the entry edge itself.
    task automatic test_cv_timeout();
        logic [8:0] exp;
        for (int k = 0; k <= 21; k++) begin
            drive(mk(1, 1, 200, 50, 100, 5, (k < 21) ? CV : ENDS));
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL cv_timeout[%0d]: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_recharge();
        row_t rows [$];
        logic [8:0] exp;
        rows = '{mk(1, 1, 190, 50, 100, 1000, ENDS),
                 mk(1, 1, 180, 50, 100, 1000, ENDS),    // vbat == vpreset holds END
                 mk(1, 1, 179, 50, 100, 1000, START),
                 mk(1, 1, 179, 50, 100, 1000, CC),
                 mk(1, 0, 190, 50, 100, 1000, IDLE),
                 mk(1, 1, 190, 50, 100, 1000, START),
                 mk(1, 1, 190, 50, 100, 1000, ENDS),    // already full
                 mk(1, 1, 190, 50, 100, 1000, ENDS)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL recharge[%0d]: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_cc();
        row_t rows [$];
        logic [8:0] exp;
        rows = '{mk(1, 1, 179, 50, 100, 1000, START),
                 mk(1, 1, 179, 50, 100, 1000, CC),
                 mk(0, 1, 179, 50, 100, 1000, IDLE),
                 mk(0, 1, 179, 50, 100, 1000, IDLE),
                 mk(1, 1, 179, 50, 100, 1000, START),
                 mk(1, 1, 179, 50, 100, 1000, CC)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_cc[%0d]: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_boundaries();
        row_t rows [$];
        logic [8:0] exp;
        rows = '{mk(1, 1, 200, 11, 100, 5, CV),
                 mk(1, 1, 200, 11, 100, 5, CV),         // ibat just above iend
                 mk(1, 1, 200, 10, 100, 5, ENDS),       // ibat == iend terminates
                 mk(1, 1, 170, 50, 100, 0, START),
                 mk(1, 1, 170, 50, 100, 0, CC),
                 mk(1, 1, 200, 50, 100, 0, CV),
                 mk(1, 1, 200, 50, 100, 0, ENDS),       // tmax=0 exits at once
                 mk(1, 0,  40, 50, 100, 1000, IDLE),
                 mk(1, 1,  40, 50, 100, 1000, START),
                 mk(1, 1,  40, 50, 100, 1000, TC),
                 mk(1, 1,  40, 50, 250, 1000, START),   // fault out of TC
                 mk(1, 1,  40, 50, 250, 1000, START),
                 mk(1, 1,  59, 50, 100, 1000, TC),
                 mk(1, 1,  60, 50, 100, 1000, CC)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL boundaries[%0d]: got %b want %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        rstz    = 1'b0;
        en      = 1'b0;
        vbat    = 8'd30;
        ibat    = 8'd100;
        vtemp   = 8'd100;
        vcutoff = 8'd60;
        vpreset = 8'd180;
        vtarget = 8'd200;
        iend    = 8'd10;
        tempmin = 8'd20;
        tempmax = 8'd220;
        tmax    = 16'd1000;
        @(posedge clk); #1;

        test_reset();
        test_full_charge();
        test_temp_fault();
        test_en_drop();
        test_cv_timeout();
        test_recharge();
        test_reset_mid_cc();
        test_boundaries();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
